// File: rtl/sfm_fp_minmax_ctx_if.sv
// sfm_fp_minmax_ctx_if: controller/tracker-side bus of the min/max context store.
// Ports (master = controller side drives requests, slave = context store):
//   clear_i          clear all contexts
//   operation_i      0 = MAX, 1 = MIN (selects the identity value)
//   cur_minmax_i     tracker's current running min/max
//   save_*           save handshake (valid/ready + context index)
//   restore_*        restore handshake (valid/ready + context index)
//   load_o/load_en_o value and one-cycle strobe towards the tracker
//   ctx_valid_o      per-context "holds a saved value" flags
//   busy_o           a restore is in flight
interface sfm_fp_minmax_ctx_if #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned NUM_CTX = 8
);
    localparam int unsigned IDX_W = $clog2(NUM_CTX);
    logic               clear_i;
    logic               operation_i;
    logic [WIDTH-1:0]   cur_minmax_i;
    logic               save_valid_i;
    logic [IDX_W-1:0]   save_idx_i;
    logic               save_ready_o;
    logic               restore_valid_i;
    logic [IDX_W-1:0]   restore_idx_i;
    logic               restore_ready_o;
    logic [WIDTH-1:0]   load_o;
    logic               load_en_o;
    logic [NUM_CTX-1:0] ctx_valid_o;
    logic               busy_o;
    modport master (
        output clear_i, operation_i, cur_minmax_i, save_valid_i, save_idx_i,
               restore_valid_i, restore_idx_i,
        input  save_ready_o, restore_ready_o, load_o, load_en_o, ctx_valid_o, busy_o
    );
    modport slave (
        input  clear_i, operation_i, cur_minmax_i, save_valid_i, save_idx_i,
               restore_valid_i, restore_idx_i,
        output save_ready_o, restore_ready_o, load_o, load_en_o, ctx_valid_o, busy_o
    );
endinterface

// File: rtl/sfm_fp_minmax_ctx.sv
// sfm_fp_minmax_ctx: per-row context store for the global min/max tracker.
// Saves the tracker's running min/max per context and restores it through a
// registered load value plus a one-cycle load strobe.
// Ports: clk_i, rst_ni (synchronous, active-low), bus (sfm_fp_minmax_ctx_if.slave).
// FPFORMAT encoding: 0 FP32, 1 FP64, 2 FP16, 3 FP8, 4 FP16ALT.
// Optional macro SFM_CTX_MERGE_EN: a save into a valid context keeps the better
// of the stored and incoming values instead of overwriting.
module sfm_fp_minmax_ctx #(
    parameter int unsigned FPFORMAT = 2,
    parameter int unsigned NUM_CTX  = 8
) (
    input logic               clk_i,
    input logic               rst_ni,
    sfm_fp_minmax_ctx_if.slave bus
);
    localparam int unsigned EXP_W = (FPFORMAT == 0) ? 8 : (FPFORMAT == 1) ? 11 : (FPFORMAT == 4) ? 8 : 5;
    localparam int unsigned MAN_W = (FPFORMAT == 0) ? 23 : (FPFORMAT == 1) ? 52 : (FPFORMAT == 2) ? 10 : (FPFORMAT == 3) ? 2 : 7;
    localparam int unsigned WIDTH = 1 + EXP_W + MAN_W;
    localparam int unsigned IDX_W = $clog2(NUM_CTX);
    localparam logic [IDX_W:0] CTX_N = NUM_CTX[IDX_W:0];

    typedef enum logic {IDLE, LOAD} state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_mem [NUM_CTX];
    logic [NUM_CTX-1:0] r_valid;
    logic [WIDTH-1:0]   r_load;
    logic               r_load_en;

    logic             w_idle, w_save, w_restore, w_save_in, w_rest_in, w_rest_hit;
    logic [WIDTH-1:0] w_ident, w_stored, w_save_val;

    // Requests are only taken in IDLE and never while clear/reset is asserted.
    assign w_idle     = (r_state == IDLE) && !bus.clear_i && rst_ni;
    assign w_save     = w_idle && bus.save_valid_i;
    assign w_restore  = w_idle && bus.restore_valid_i;
    assign w_save_in  = {1'b0, bus.save_idx_i} < CTX_N;
    assign w_rest_in  = {1'b0, bus.restore_idx_i} < CTX_N;
    assign w_rest_hit = w_rest_in && r_valid[bus.restore_idx_i];
    assign w_ident    = {~bus.operation_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    assign w_stored   = w_rest_in ? r_mem[bus.restore_idx_i] : w_ident;

`ifdef SFM_CTX_MERGE_EN
    logic [WIDTH-1:0] w_old;
    logic             w_better;

    // IEEE ordering on raw bits: NaNs never win, +0 and -0 compare equal.
    function automatic logic fp_gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic a_nan, b_nan;
        logic [WIDTH-2:0] a_mag, b_mag;
        a_nan = (&a[WIDTH-2:MAN_W]) && (|a[MAN_W-1:0]);
        b_nan = (&b[WIDTH-2:MAN_W]) && (|b[MAN_W-1:0]);
        a_mag = a[WIDTH-2:0];
        b_mag = b[WIDTH-2:0];
        return (a_nan || b_nan || (a_mag == '0 && b_mag == '0)) ? 1'b0 :
               (a[WIDTH-1] != b[WIDTH-1]) ? !a[WIDTH-1] :
               a[WIDTH-1] ? (a_mag < b_mag) : (a_mag > b_mag);
    endfunction

    assign w_old      = w_save_in ? r_mem[bus.save_idx_i] : bus.cur_minmax_i;
    assign w_better   = bus.operation_i ? fp_gt(w_old, bus.cur_minmax_i) : fp_gt(bus.cur_minmax_i, w_old);
    assign w_save_val = (w_save_in && r_valid[bus.save_idx_i] && !w_better) ? w_old : bus.cur_minmax_i;
`else
    assign w_save_val = bus.cur_minmax_i;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_load    <= '0;
            r_load_en <= 1'b0;
            r_valid   <= '0;
        end else if (bus.clear_i) begin
            r_state   <= IDLE;
            r_load_en <= 1'b0;
            r_valid   <= '0;
        end else begin
            r_state   <= w_restore ? LOAD : IDLE;
            r_load_en <= w_restore;
            // Restore reads the array before this cycle's save lands (no bypass).
            if (w_restore)
                r_load <= w_rest_hit ? w_stored : w_ident;
            if (w_save && w_save_in) begin
                r_mem[bus.save_idx_i]   <= w_save_val;
                r_valid[bus.save_idx_i] <= 1'b1;
            end
        end
    end

    // A clear or reset arriving during LOAD suppresses the strobe in that same cycle.
    assign bus.load_en_o       = r_load_en && !bus.clear_i && rst_ni;
    assign bus.busy_o          = (r_state == LOAD) && !bus.clear_i && rst_ni;
    assign bus.save_ready_o    = w_idle;
    assign bus.restore_ready_o = w_idle;
    assign bus.load_o          = r_load;
    assign bus.ctx_valid_o     = r_valid;
endmodule

// File: tb/tb_sfm_fp_minmax_ctx.sv
// tb_sfm_fp_minmax_ctx: directed self-checking bench for the min/max context store (FP16, 6 contexts).
module tb_sfm_fp_minmax_ctx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    sfm_fp_minmax_ctx_if #(.WIDTH(16), .NUM_CTX(6)) bus ();

    sfm_fp_minmax_ctx #(.FPFORMAT(2), .NUM_CTX(6)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.save_valid_i    = 1'b0;
        bus.restore_valid_i = 1'b0;
        bus.clear_i         = 1'b0;
    endtask

    task automatic save(input logic [2:0] idx, input logic [15:0] v);
        bus.save_valid_i = 1'b1;
        bus.save_idx_i   = idx;
        bus.cur_minmax_i = v;
    endtask

    task automatic restore(input logic [2:0] idx);
        bus.restore_valid_i = 1'b1;
        bus.restore_idx_i   = idx;
    endtask

    initial begin
        idle_in();
        bus.operation_i   = 1'b0;
        bus.cur_minmax_i  = '0;
        bus.save_idx_i    = '0;
        bus.restore_idx_i = '0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_load", bus.load_o, 16'h0000);
        chk("rst_en", bus.load_en_o, 0);
        chk("rst_valid", bus.ctx_valid_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_rdy", {bus.save_ready_o, bus.restore_ready_o}, 2'b11);

        restore(3);
        tick();
        idle_in();
        chk("max_id_en", bus.load_en_o, 1);
        chk("max_id", bus.load_o, 16'hFC00);
        chk("load_busy", bus.busy_o, 1);
        chk("load_rdy", {bus.save_ready_o, bus.restore_ready_o}, 2'b00);
        tick();
        chk("max_id_en_off", bus.load_en_o, 0);
        chk("max_id_hold", bus.load_o, 16'hFC00);
        chk("idle_busy", bus.busy_o, 0);
        bus.operation_i = 1'b1;
        restore(3);
        tick();
        idle_in();
        bus.operation_i = 1'b0;
        chk("min_id", bus.load_o, 16'h7C00);
        chk("min_id_en", bus.load_en_o, 1);
        tick();

        save(2, 16'h4200);
        tick();
        idle_in();
        chk("save_valid", bus.ctx_valid_o, 6'b000100);
        restore(2);
        tick();
        idle_in();
        chk("rest2", bus.load_o, 16'h4200);
        chk("rest2_rdy_lo", bus.restore_ready_o, 0);
        tick();
        chk("rest2_rdy_hi", bus.restore_ready_o, 1);

        save(5, 16'h3C00);
        tick();
        save(5, 16'h4400);
        restore(5);
        tick();
        idle_in();
        chk("same_cyc_old", bus.load_o, 16'h3C00);
        chk("same_cyc_valid", bus.ctx_valid_o, 6'b100100);
        tick();
        restore(5);
        tick();
        idle_in();
        chk("same_cyc_new", bus.load_o, 16'h4400);
        tick();

        save(1, 16'h4000);
        tick();
        save(4, 16'hC000);
        tick();
        idle_in();
        chk("b2b_saves", bus.ctx_valid_o, 6'b110110);
        restore(1);
        tick();
        restore(4);
        chk("b2b_n1_en", bus.load_en_o, 1);
        chk("b2b_n1_val", bus.load_o, 16'h4000);
        tick();
        chk("b2b_n2_en", bus.load_en_o, 0);
        tick();
        idle_in();
        chk("b2b_n3_en", bus.load_en_o, 1);
        chk("b2b_n3_val", bus.load_o, 16'hC000);
        tick();

        save(6, 16'h4500);
        tick();
        idle_in();
        chk("oor_save", bus.ctx_valid_o, 6'b110110);
        restore(7);
        tick();
        idle_in();
        chk("oor_rest", bus.load_o, 16'hFC00);
        chk("oor_rest_en", bus.load_en_o, 1);
        tick();

        restore(2);
        tick();
        idle_in();
        bus.clear_i = 1'b1;
        save(0, 16'h4600);
        #1;
        chk("clr_abort_en", bus.load_en_o, 0);
        chk("clr_rdy", {bus.save_ready_o, bus.restore_ready_o}, 2'b00);
        tick();
        idle_in();
        chk("clr_valid", bus.ctx_valid_o, 0);
        chk("clr_busy", bus.busy_o, 0);
        chk("clr_en", bus.load_en_o, 0);
        restore(2);
        tick();
        idle_in();
        chk("clr_ident", bus.load_o, 16'hFC00);
        tick();

        save(0, 16'h4200);
        tick();
        save(0, 16'h3C00);
        tick();
        idle_in();
        restore(0);
        tick();
        idle_in();
`ifdef SFM_CTX_MERGE_EN
        chk("merge_max", bus.load_o, 16'h4200);
`else
        chk("overwrite", bus.load_o, 16'h3C00);
`endif
        tick();

        restore(0);
        tick();
        idle_in();
        rst_n = 1'b0;
        #1;
        chk("rst_abort_en", bus.load_en_o, 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst2_valid", bus.ctx_valid_o, 0);
        chk("rst2_load", bus.load_o, 16'h0000);
        chk("rst2_busy", bus.busy_o, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
